sync_fifo_ext: RTL and testbench
================================

Name: sync_fifo_ext

Overview:
Parametrised synchronous FIFO that supersedes the basic single-mode sync FIFO. It adds:
- non-power-of-two depth;
- an occupancy count;
- programmable almost-full and almost-empty flags;
- a selectable read mode (first-word-fall-through or registered);
- synchronous flush;
- sticky overflow and underflow error flags.

It is used as the general-purpose buffering primitive between single-clock pipeline stages.

Parameters:
FIFO_WIDTH, 8, data width in bits (>=1)
FIFO_DEPTH, 16, number of entries (>=2, any integer, not restricted to powers of two)
AFULL_THRESH, FIFO_DEPTH-2, fifo_afull asserted when count >= this value (1..FIFO_DEPTH)
AEMPTY_THRESH, 2, fifo_aempty asserted when count <= this value (0..FIFO_DEPTH-1)
FWFT, 1, 1 = first-word-fall-through read; 0 = registered read with one-cycle latency

Ports:
fifo_clk  in  1  clock, all state updates on the rising edge
fifo_rst_n  in  1  reset, asynchronous, active-low
fifo_flush  in  1  synchronous flush, empties the FIFO
fifo_wen  in  1  write request
fifo_wdata  in  FIFO_WIDTH  write data
fifo_full  out  1  count == FIFO_DEPTH
fifo_afull  out  1  almost full
fifo_ren  in  1  read request
fifo_rdata  out  FIFO_WIDTH  read data
fifo_rvalid  out  1  read data valid (meaning depends on FWFT)
fifo_empty  out  1  count == 0
fifo_aempty  out  1  almost empty
fifo_count  out  $clog2(FIFO_DEPTH+1)  current occupancy
fifo_clr_err  in  1  clears the sticky error flags
fifo_overflow  out  1  sticky: a write was dropped
fifo_underflow  out  1  sticky: a read was dropped

Behaviour:
- Reset (async assert, sync deassert at the flop level): pointers=0, count=0, full=0, afull=0, empty=1, aempty=1, overflow=0, underflow=0, rdata=0, rvalid=0. Memory array is not reset.
- Pointers: rptr and wptr range 0..FIFO_DEPTH-1 and wrap from FIFO_DEPTH-1 to 0. Occupancy is held in an explicit count register, never derived from the pointers.
- Read accepted: rd_acc = ren & !empty. Read requested while empty is dropped and sets underflow. This holds even with a simultaneous write: there is no empty bypass.
- Write accepted: wr_acc = wen & (!full | rd_acc). Write while full with an accepted read is allowed and count stays FIFO_DEPTH. Write while full without a read is dropped, sets overflow, and memory is unchanged.
- Count update: count_next = count + wr_acc - rd_acc. full, empty, afull and aempty are decoded combinationally from the count register, so they change in the cycle after the accepted access.
- FWFT=1:
  - rdata = mem[rptr] when !empty, otherwise 0.
  - rvalid = !empty.
  - An accepted read advances rptr, so the next word appears on the following cycle.
- FWFT=0:
  - On rd_acc, rdata is loaded from mem[rptr] and rvalid=1 in the next cycle.
  - rvalid is 0 in any cycle not following an accepted read.
  - rdata holds its last value while no read is accepted.
- Flush: takes priority over wen/ren in the same cycle. Next cycle: pointers=0, count=0, empty=1, rvalid=0. The flush itself does not set overflow/underflow and does not clear them. rdata holds in FWFT=0 and reads 0 in FWFT=1.
- Error flags:
  - clr_err clears overflow and underflow.
  - If a set condition and clr_err occur in the same cycle, set wins.
  - Flags remain asserted until cleared or reset.
- Ordering: written data reads back in strict FIFO order across pointer wrap.

Test Plan:
1. DEPTH=5, FWFT=1: write 0x11..0x15 -> full=1, count=5, afull=1 from count 3. Sixth write 0x16 -> overflow=1, and reads return 0x11..0x15 in order, then empty=1.
2. DEPTH=5, full, then wen+ren together for 7 cycles (data 0x20..0x26) -> count stays 5, full stays 1, no overflow. Drain yields 0x22..0x26, exercising pointer wrap.
3. FWFT=0: write 0xA5, then pulse ren -> rvalid=1 with rdata=0xA5 exactly one cycle after ren, then rvalid=0 and rdata holds 0xA5.
4. Empty FIFO, ren=1 and wen=1 with 0x3C -> underflow=1, count=1, next-cycle rdata=0x3C (FWFT=1). Then clr_err=1 -> underflow=0.
5. Count=3, flush asserted with wen=1 in the same cycle -> next cycle count=0, empty=1, aempty=1, and the write is ignored.
6. Assert fifo_rst_n=0 asynchronously mid-burst at count=4 -> outputs return to reset values immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/sync_fifo_ext_if.sv
// Handshake/data bundle between a sync_fifo_ext instance and its user.
// Latency: n/a (wires only).
// Backpressure: n/a; the full/afull and empty/aempty status lines carry it.
// Ports: master drives flush/wen/wdata/ren/clr_err and observes status, read data and error flags;
//        slave is the FIFO side.
interface sync_fifo_ext_if #(
  parameter int FIFO_WIDTH = 8,
  parameter int FIFO_DEPTH = 16
);
  localparam int CNT_W = $clog2(FIFO_DEPTH + 1);

  logic                  fifo_flush;
  logic                  fifo_wen;
  logic [FIFO_WIDTH-1:0] fifo_wdata;
  logic                  fifo_full;
  logic                  fifo_afull;
  logic                  fifo_ren;
  logic [FIFO_WIDTH-1:0] fifo_rdata;
  logic                  fifo_rvalid;
  logic                  fifo_empty;
  logic                  fifo_aempty;
  logic [CNT_W-1:0]      fifo_count;
  logic                  fifo_clr_err;
  logic                  fifo_overflow;
  logic                  fifo_underflow;

  modport master (
    output fifo_flush, fifo_wen, fifo_wdata, fifo_ren, fifo_clr_err,
    input  fifo_full, fifo_afull, fifo_rdata, fifo_rvalid, fifo_empty,
           fifo_aempty, fifo_count, fifo_overflow, fifo_underflow
  );

  modport slave (
    input  fifo_flush, fifo_wen, fifo_wdata, fifo_ren, fifo_clr_err,
    output fifo_full, fifo_afull, fifo_rdata, fifo_rvalid, fifo_empty,
           fifo_aempty, fifo_count, fifo_overflow, fifo_underflow
  );
endinterface

// File: rtl/sync_fifo_ext.sv
// Single-clock FIFO with any depth, occupancy count, almost flags, flush and sticky error flags.
// Latency: FWFT=1 head word visible combinationally; FWFT=0 read data one cycle after an accepted read.
// Backpressure: writes to a full FIFO are dropped (overflow) unless a read is accepted in the same cycle;
//               reads from an empty FIFO are dropped (underflow).
// Ports: fifo_clk, fifo_rst_n (async, active-low), bus (sync_fifo_ext_if.slave).
module sync_fifo_ext #(
  parameter int FIFO_WIDTH    = 8,
  parameter int FIFO_DEPTH    = 16,
  parameter int AFULL_THRESH  = FIFO_DEPTH - 2,
  parameter int AEMPTY_THRESH = 2,
  parameter bit FWFT          = 1'b1
) (
  input logic            fifo_clk,
  input logic            fifo_rst_n,
  sync_fifo_ext_if.slave bus
);
  localparam int CW = $clog2(FIFO_DEPTH + 1);
  localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam logic [CW-1:0] DEPTH_C  = CW'(FIFO_DEPTH);
  localparam logic [CW-1:0] AFULL_C  = CW'(AFULL_THRESH);
  localparam logic [CW-1:0] AEMPTY_C = CW'(AEMPTY_THRESH);
  localparam logic [PW-1:0] LAST_PTR = PW'(FIFO_DEPTH - 1);

  logic [FIFO_WIDTH-1:0] mem [FIFO_DEPTH];

  logic [PW-1:0]         wptr_q, wptr_d;
  logic [PW-1:0]         rptr_q, rptr_d;
  logic [CW-1:0]         count_q, count_d;
  logic                  overflow_q, overflow_d;
  logic                  underflow_q, underflow_d;
  logic [FIFO_WIDTH-1:0] rdata_q, rdata_d;
  logic                  rvalid_q, rvalid_d;

  logic                  full, empty, rd_acc, wr_acc, ovf_set, udf_set;
  logic [FIFO_WIDTH-1:0] head;

  // Status decodes come from the count register only, so they lag an access by one cycle.
  assign full  = (count_q == DEPTH_C);
  assign empty = (count_q == '0);
  assign head  = mem[rptr_q];

  // Flush overrides both requests. A read on empty is never bypassed by a same-cycle write.
  assign rd_acc  = bus.fifo_ren & ~empty & ~bus.fifo_flush;
  assign wr_acc  = bus.fifo_wen & (~full | rd_acc) & ~bus.fifo_flush;
  assign ovf_set = bus.fifo_wen & full & ~rd_acc & ~bus.fifo_flush;
  assign udf_set = bus.fifo_ren & empty & ~bus.fifo_flush;

  always_comb begin
    wptr_d   = wptr_q;
    rptr_d   = rptr_q;
    count_d  = count_q;
    rdata_d  = rdata_q;
    rvalid_d = 1'b0;
    if (bus.fifo_flush) begin
      wptr_d  = '0;
      rptr_d  = '0;
      count_d = '0;
    end else begin
      if (wr_acc) begin
        wptr_d = (wptr_q == LAST_PTR) ? '0 : wptr_q + PW'(1);
      end
      if (rd_acc) begin
        rptr_d   = (rptr_q == LAST_PTR) ? '0 : rptr_q + PW'(1);
        rdata_d  = head;
        rvalid_d = 1'b1;
      end
      count_d = count_q + CW'(wr_acc) - CW'(rd_acc);
    end
    // Setting beats a same-cycle clear.
    overflow_d  = ovf_set | (overflow_q  & ~bus.fifo_clr_err);
    underflow_d = udf_set | (underflow_q & ~bus.fifo_clr_err);
  end

  always_ff @(posedge fifo_clk or negedge fifo_rst_n) begin
    if (!fifo_rst_n) begin
      wptr_q      <= '0;
      rptr_q      <= '0;
      count_q     <= '0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
      rdata_q     <= '0;
      rvalid_q    <= 1'b0;
    end else begin
      wptr_q      <= wptr_d;
      rptr_q      <= rptr_d;
      count_q     <= count_d;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
      rdata_q     <= rdata_d;
      rvalid_q    <= rvalid_d;
    end
  end

  // Storage is deliberately left out of reset.
  always_ff @(posedge fifo_clk) begin
    if (wr_acc) begin
      mem[wptr_q] <= bus.fifo_wdata;
    end
  end

  assign bus.fifo_full      = full;
  assign bus.fifo_empty     = empty;
  assign bus.fifo_afull     = (count_q >= AFULL_C);
  assign bus.fifo_aempty    = (count_q <= AEMPTY_C);
  assign bus.fifo_count     = count_q;
  assign bus.fifo_overflow  = overflow_q;
  assign bus.fifo_underflow = underflow_q;
  assign bus.fifo_rdata     = FWFT ? (empty ? '0 : head) : rdata_q;
  assign bus.fifo_rvalid    = FWFT ? ~empty : rvalid_q;
endmodule

// File: tb/tb_sync_fifo_ext.sv
// Bench for sync_fifo_ext: one FWFT and one registered-read instance (depth 5) share the same stimulus.
// A queue-based reference model tracks contents and flags; read words go to scoreboards popped by a monitor.
module tb_sync_fifo_ext;
  localparam int DEPTH = 5;
  localparam int AF    = 3;
  localparam int AE    = 2;

  logic clk;
  logic rst_n;

  sync_fifo_ext_if #(.FIFO_WIDTH(8), .FIFO_DEPTH(DEPTH)) if1 ();
  sync_fifo_ext_if #(.FIFO_WIDTH(8), .FIFO_DEPTH(DEPTH)) if0 ();

  sync_fifo_ext #(.FIFO_WIDTH(8), .FIFO_DEPTH(DEPTH), .AFULL_THRESH(AF),
                  .AEMPTY_THRESH(AE), .FWFT(1'b1)) dut1 (
    .fifo_clk(clk), .fifo_rst_n(rst_n), .bus(if1));

  sync_fifo_ext #(.FIFO_WIDTH(8), .FIFO_DEPTH(DEPTH), .AFULL_THRESH(AF),
                  .AEMPTY_THRESH(AE), .FWFT(1'b0)) dut0 (
    .fifo_clk(clk), .fifo_rst_n(rst_n), .bus(if0));

  int n_chk = 0;
  int n_err = 0;

  // Reference model
  logic [7:0] m_q[$];
  bit         m_ovf, m_udf, m_rv0;
  logic [7:0] m_rd0;
  logic [7:0] exp1_q[$];
  logic [7:0] exp0_q[$];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_q.delete();
    exp1_q.delete();
    exp0_q.delete();
    m_ovf = 1'b0;
    m_udf = 1'b0;
    m_rv0 = 1'b0;
    m_rd0 = 8'h00;
  endtask

  task automatic set_in(input bit fl, input bit we, input bit [7:0] wd, input bit re, input bit cl);
    if1.fifo_flush = fl; if1.fifo_wen = we; if1.fifo_wdata = wd; if1.fifo_ren = re; if1.fifo_clr_err = cl;
    if0.fifo_flush = fl; if0.fifo_wen = we; if0.fifo_wdata = wd; if0.fifo_ren = re; if0.fifo_clr_err = cl;
  endtask

  task automatic check_status();
    int c;
    logic [5:0] fl_exp;
    logic [7:0] head_exp;
    c = m_q.size();
    fl_exp = {c == DEPTH, c >= AF, c == 0, c <= AE, m_ovf, m_udf};
    head_exp = (c != 0) ? m_q[0] : 8'h00;
    chk("count_fwft", int'(if1.fifo_count), c);
    chk("count_reg",  int'(if0.fifo_count), c);
    chk("flags_fwft {full,afull,empty,aempty,ovf,udf}",
        int'({if1.fifo_full, if1.fifo_afull, if1.fifo_empty, if1.fifo_aempty,
              if1.fifo_overflow, if1.fifo_underflow}), int'(fl_exp));
    chk("flags_reg {full,afull,empty,aempty,ovf,udf}",
        int'({if0.fifo_full, if0.fifo_afull, if0.fifo_empty, if0.fifo_aempty,
              if0.fifo_overflow, if0.fifo_underflow}), int'(fl_exp));
    chk("rvalid_fwft", int'(if1.fifo_rvalid), int'(c != 0));
    chk("rdata_fwft",  int'(if1.fifo_rdata), int'(head_exp));
    chk("rvalid_reg",  int'(if0.fifo_rvalid), int'(m_rv0));
    chk("rdata_reg",   int'(if0.fifo_rdata), int'(m_rd0));
  endtask

  // One clock cycle: check current state, apply inputs, advance the model.
  task automatic cyc(input bit fl, input bit we, input bit [7:0] wd, input bit re, input bit cl);
    bit rd, wr, ovf_set, udf_set;
    logic [7:0] w;
    @(negedge clk);
    check_status();
    set_in(fl, we, wd, re, cl);
    rd      = re && (m_q.size() != 0) && !fl;
    wr      = we && ((m_q.size() < DEPTH) || rd) && !fl;
    ovf_set = we && !fl && (m_q.size() == DEPTH) && !rd;
    udf_set = re && !fl && (m_q.size() == 0);
    m_ovf = ovf_set ? 1'b1 : (cl ? 1'b0 : m_ovf);
    m_udf = udf_set ? 1'b1 : (cl ? 1'b0 : m_udf);
    m_rv0 = rd;
    if (rd) begin
      w = m_q.pop_front();
      exp1_q.push_back(w);
      exp0_q.push_back(w);
      m_rd0 = w;
    end
    if (fl) m_q.delete();
    if (wr) m_q.push_back(wd);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
  endtask

  // Monitor: pops the scoreboards whenever a DUT delivers a word.
  initial begin
    forever begin
      @(negedge clk);
      #2;
      if (rst_n) begin
        if (if1.fifo_ren && if1.fifo_rvalid && !if1.fifo_flush) begin
          if (exp1_q.size() == 0) chk("sb_fwft_unexpected_read", 1, 0);
          else chk("sb_fwft_data", int'(if1.fifo_rdata), int'(exp1_q.pop_front()));
        end
        if (if0.fifo_rvalid) begin
          if (exp0_q.size() == 0) chk("sb_reg_unexpected_rvalid", 1, 0);
          else chk("sb_reg_data", int'(if0.fifo_rdata), int'(exp0_q.pop_front()));
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

  initial begin
    model_reset();
    rst_n = 1'b0;
    set_in(1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
    #12;
    check_status();
    @(negedge clk);
    rst_n = 1'b1;

    // Fill past full: afull from count 3, sixth write dropped with overflow; drain in order.
    for (int i = 0; i < 6; i++) cyc(1'b0, 1'b1, 8'(8'h11 + i), 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) cyc(1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
    idle(2);
    cyc(1'b0, 1'b0, 8'h00, 1'b0, 1'b1);

    // Full with simultaneous read+write across pointer wrap.
    for (int i = 0; i < 5; i++) cyc(1'b0, 1'b1, 8'(8'h30 + i), 1'b0, 1'b0);
    for (int i = 0; i < 7; i++) cyc(1'b0, 1'b1, 8'(8'h20 + i), 1'b1, 1'b0);
    for (int i = 0; i < 5; i++) cyc(1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
    idle(2);

    // Registered-read latency and hold.
    cyc(1'b0, 1'b1, 8'hA5, 1'b0, 1'b0);
    idle(1);
    cyc(1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
    idle(3);

    // Read+write on empty: read dropped, underflow set, write lands; then clear.
    cyc(1'b0, 1'b1, 8'h3C, 1'b1, 1'b0);
    idle(1);
    cyc(1'b0, 1'b0, 8'h00, 1'b0, 1'b1);
    cyc(1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
    idle(2);

    // Flush with a same-cycle write at count 3.
    for (int i = 0; i < 3; i++) cyc(1'b0, 1'b1, 8'(8'h50 + i), 1'b0, 1'b0);
    cyc(1'b1, 1'b1, 8'h99, 1'b0, 1'b0);
    idle(2);

    // Asynchronous reset mid-burst at count 4.
    for (int i = 0; i < 5; i++) cyc(1'b0, 1'b1, 8'(8'h60 + i), 1'b0, 1'b0);
    #3;
    chk("pre_reset_count", int'(if1.fifo_count), 4);
    rst_n = 1'b0;
    #1;
    model_reset();
    check_status();
    set_in(1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    idle(1);

    // Randomized traffic.
    for (int i = 0; i < 400; i++) begin
      cyc(($urandom_range(0, 39) == 0), ($urandom_range(0, 9) < 6), 8'($urandom),
          ($urandom_range(0, 9) < 5), ($urandom_range(0, 19) == 0));
    end
    idle(3);
    #3;
    chk("sb_fwft_leftover", exp1_q.size(), 0);
    chk("sb_reg_leftover", exp0_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
